// File: rtl/async_fifo_wr_ctrl_if.sv
// async_fifo_wr_ctrl_if: producer/read-pointer side and memory side signals of the async FIFO write controller
interface async_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_inc;
  logic [ADDR_WIDTH:0]   gray_rd_ptr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   gray_wr_ptr;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  wr_overflow;
  modport master (
    output wr_inc, gray_rd_ptr,
    input  wr_en, wr_addr, gray_wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow
  );
  modport slave (
    input  wr_inc, gray_rd_ptr,
    output wr_en, wr_addr, gray_wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-domain pointer, full and overflow logic of an async FIFO; ASYNC_FIFO_WR_CTRL_LEVEL_EN adds wr_level/wr_almost_full
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input logic                 W_CLK,
  input logic                 W_RST,
  async_fifo_wr_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] bin_q, bin_d, gray_q, gray_d, rq_sync;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          full_q, full_d, ovf_q, ovf_d, wr_en;
  assign rq_sync = sync_q[SYNC_STAGES-1];
  assign wr_en   = bus.wr_inc & ~full_q;
  assign bin_d   = bin_q + PW'(wr_en);
  assign gray_d  = bin_d ^ (bin_d >> 1);
  // full when write pointer is one lap ahead: Gray form differs in the two MSBs only
  assign full_d  = gray_d == (rq_sync ^ {2'b11, {(PW-2){1'b0}}});
  assign ovf_d   = ovf_q | (bus.wr_inc & full_q);
  always_ff @(posedge W_CLK or posedge W_RST)
    if (W_RST) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      sync_q[0] <= bus.gray_rd_ptr;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = bin_q[ADDR_WIDTH-1:0];
  assign bus.gray_wr_ptr = gray_q;
  assign bus.wr_full     = full_q;
  assign bus.wr_overflow = ovf_q;
`ifdef ASYNC_FIFO_WR_CTRL_LEVEL_EN
  logic [PW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  // stale synchronised read pointer only overestimates the level, never under
  assign level_d = bin_d - g2b(rq_sync);
  assign afull_d = level_d >= PW'(AFULL_THRESH);
  always_ff @(posedge W_CLK or posedge W_RST)
    if (W_RST) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  assign bus.wr_level       = level_q;
  assign bus.wr_almost_full = afull_q;
`else
  assign bus.wr_level       = '0;
  assign bus.wr_almost_full = 1'b0;
`endif
endmodule
